// File: rtl/unified_mem_arbiter.sv
// Arbiter that lets the IF and MEM stages share one single-port memory.
// Data accesses win over fetches; one transaction is in flight at a time.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              err
);

    // The counter only has to reach TIMEOUT-1: the abort fires on that busy cycle.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DM_BUSY = 2'd1,
        IF_BUSY = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              dm_access;
    logic              dm_pend;
    logic              if_pend;
    logic              dm_served;
    logic              if_served;
    logic              busy;
    logic              tmo_hit;
    logic              done;
    logic              issue_dm;
    logic              issue_if;
    logic              cap_dm;
    logic              cap_if;
    logic [DATA_W-1:0] cap_data;
    logic [CNT_W-1:0]  tmo_cnt;

    assign dm_access = dm_read | dm_write;
    assign dm_pend   = dm_access & ~dm_served;
    assign if_pend   = if_req & ~if_served;
    assign busy      = (state_q != IDLE);
    assign tmo_hit   = busy & ~mem_ack & (tmo_cnt == TMO_LAST);
    assign done      = busy & (mem_ack | tmo_hit);
    // An aborted transaction completes with zero data.
    assign cap_data  = mem_ack ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dm_pend) begin
                    state_d = DM_BUSY;
                end else if (if_pend) begin
                    state_d = IF_BUSY;
                end
            end
            DM_BUSY: begin
                if (done) begin
                    state_d = if_pend ? IF_BUSY : IDLE;
                end
            end
            IF_BUSY: begin
                if (done) begin
                    state_d = dm_pend ? DM_BUSY : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall    = dm_pend | if_pend;
        issue_dm = 1'b0;
        issue_if = 1'b0;
        cap_dm   = 1'b0;
        cap_if   = 1'b0;
        case (state_q)
            IDLE: begin
                issue_dm = dm_pend;
                issue_if = ~dm_pend & if_pend;
            end
            DM_BUSY: begin
                cap_dm   = done;
                issue_if = done & if_pend;
            end
            IF_BUSY: begin
                cap_if   = done;
                issue_dm = done & dm_pend;
            end
            default: begin
                issue_dm = 1'b0;
            end
        endcase
    end

    // Memory request registers; the follow-on requester is issued on the ack edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (issue_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_write;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
        end else if (issue_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
        end else if (!busy || done) begin
            mem_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if (cap_dm && !mem_we) begin
                dm_rdata <= cap_data;
            end
            if (cap_if) begin
                if_rdata <= cap_data;
            end
        end
    end

    // A capture outranks the advance-clear so a flushed result still marks its requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_served <= 1'b0;
            if_served <= 1'b0;
        end else begin
            if (cap_dm) begin
                dm_served <= 1'b1;
            end else if (!stall) begin
                dm_served <= 1'b0;
            end
            if (cap_if) begin
                if_served <= 1'b1;
            end else if (!stall) begin
                if_served <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (busy && !done) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (tmo_hit) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw data access) of the five-stage pipeline.
- Serialises the two requesters with a small FSM, data access first, and holds one outstanding memory transaction at a time.
- Drives the pipeline-wide stall that feeds the control unit's stall input and the pipeline-register enables.

Parameters:
- ADDR_W, 32, byte address width of all address ports.
- DATA_W, 32, data word width.
- TIMEOUT, 15, max cycles in a busy state waiting for mem_ack before abort (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  IF stage requests an instruction word.
- if_addr  in  ADDR_W  fetch address (PC); held stable while stall=1.
- if_rdata  out  DATA_W  captured instruction word.
- dm_read  in  1  MemRead from the EX/MEM register.
- dm_write  in  1  MemWrite from the EX/MEM register.
- dm_addr  in  ADDR_W  data address (ALU result).
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  captured load data.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1.
- mem_ack  in  1  memory completes the current request this cycle.
- stall  out  1  freeze the pipeline; combinational.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; if_rdata=0, dm_rdata=0; flags if_served=0 and dm_served=0; timeout counter=0; err=0. A transaction in flight is dropped and no capture occurs.
- dm_access = dm_read | dm_write. Write has precedence: sw raises both signals, and dm_write=1 gives mem_we=1 regardless of dm_read.
- stall = (dm_access & ~dm_served) | (if_req & ~if_served).
- The pipeline advances on a cycle with stall=0. On that edge both served flags clear.
- States: IDLE, DM_BUSY, IF_BUSY.
- IDLE:
  - If dm_access & ~dm_served: load mem_addr=dm_addr, mem_wdata=dm_wdata, mem_we=dm_write, mem_req=1, go to DM_BUSY.
  - Else if if_req & ~if_served: load mem_addr=if_addr, mem_we=0, mem_req=1, go to IF_BUSY.
  - Else: mem_req=0.
- DM_BUSY / IF_BUSY:
  - mem_* outputs are held constant. The timeout counter increments each cycle.
  - The memory samples writes on mem_req & mem_ack.
  - On mem_ack in DM_BUSY: dm_rdata <= mem_rdata (loads only; stores leave dm_rdata unchanged); dm_served <= 1.
  - On mem_ack in IF_BUSY: if_rdata <= mem_rdata; if_served <= 1.
  - After ack, if the other requester is pending and unserved, issue it directly on the same edge with no IDLE bubble. Otherwise set mem_req<=0 and go to IDLE.
  - Timeout: if the counter reaches TIMEOUT with no ack, treat the transaction as acked with rdata=0, set err=1, and clear the counter. err clears only on reset.
- Latency: a single request with zero-wait memory (mem_ack high on the first mem_req cycle) gives stall for 2 cycles (the issue cycle and the ack cycle). Both requesters pending gives stall for 3 cycles minimum.
- Captured rdata stays stable until the next capture for that requester.
- Requests that drop while unserved (e.g. an IF flush) leave the in-flight transaction to complete. The result is captured and the served flag is set; it is then cleared at the next pipeline advance.
- Write ordering is guaranteed: a data access is always issued before a fetch pending in the same cycle.

Test Plan:
- Reset with mem_req high mid-transaction → mem_req, mem_we, stall, err all 0 immediately (async); if_rdata=0.
- if_req=1, if_addr=0x0000_0040, mem_ack on first mem_req cycle, mem_rdata=0x8C08_0004 → stall high 2 cycles, mem_addr=0x40, mem_we=0, if_rdata=0x8C08_0004, stall low on cycle 3.
- Same cycle: if_req=1 (addr 0x44); dm_read=1, dm_write=1 (sw) with dm_addr=0x100, dm_wdata=0xDEAD_BEEF; zero-wait memory → first transaction mem_we=1, addr 0x100, data 0xDEADBEEF. Fetch to 0x44 is issued on the next edge with no IDLE cycle. stall high 3 cycles.
- lw dm_read=1 at dm_addr=0x200, memory acks after 3 wait cycles with 0x1234_5678 → stall high 5 cycles, dm_rdata=0x12345678, if_rdata unchanged.
- TIMEOUT=15, mem_ack held 0 on a fetch → at the 15th busy cycle, if_rdata=0, err=1 and stays 1. Subsequent requests still complete normally.
- if_req dropped mid-transaction (flush), ack arrives → if_rdata captured, stall falls. The next if_req is re-fetched after the pipeline advance.
